// File: rtl/zero_stream_pkg.sv
// Shared types for the Zero stream machine: opcodes, FSM state codes and width helpers.
package zero_stream_pkg;

    typedef enum logic [3:0] {
        OP_LABEL  = 4'd0,
        OP_INSIZE = 4'd1,
        OP_IN     = 4'd2,
        OP_OUT    = 4'd3,
        OP_JMP    = 4'd4,
        OP_JFALSE = 4'd5,
        OP_JTRUE  = 4'd6,
        OP_MOV    = 4'd7,
        OP_ADD    = 4'd8,
        OP_SUB    = 4'd9,
        OP_HALT   = 4'd15
    } opcode_e;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_EXEC     = 3'd1;
    localparam logic [2:0] S_WAIT_IN  = 3'd2;
    localparam logic [2:0] S_WAIT_OUT = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    function automatic int instr_w(input int opnd_w);
        return 4 + 3 * opnd_w;
    endfunction

    // Count needs one extra bit so a full FIFO is distinguishable from empty.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/zero_stream_fifo.sv
// Synchronous input FIFO with occupancy count; pushes while full and pops while empty are dropped.
module zero_stream_fifo import zero_stream_pkg::*; #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic [cnt_w(DEPTH)-1:0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/zero_stream_machine.sv
// Loadable Zero-instruction interpreter with streamed input (FIFO) and output (valid/ready).
// Define ZERO_STEP_LIMIT_EN to abort with error once step_count reaches MAX_STEPS.
module zero_stream_machine import zero_stream_pkg::*; #(
    parameter int WIDTH     = 12,
    parameter int NLOCAL    = 16,
    parameter int NPROG     = 64,
    parameter int IN_DEPTH  = 8,
    parameter int OPND_W    = 8,
    parameter int MAX_STEPS = 1024
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         prog_we,
    input  logic [OPND_W-1:0]            prog_addr,
    input  logic [instr_w(OPND_W)-1:0]   prog_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         running,
    output logic                         finished,
    output logic                         success,
    output logic                         error,
    output logic [31:0]                  step_count
);
    localparam int PW  = $clog2(NPROG);
    localparam int LW  = $clog2(NLOCAL);
    localparam int CW  = cnt_w(IN_DEPTH);
    localparam int IPW = OPND_W + 1;

    typedef struct packed {
        logic [3:0]        op;
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic [OPND_W-1:0] c;
    } instr_t;

    instr_t           prog [NPROG];
    logic [WIDTH-1:0] lmem [NLOCAL];
    logic [2:0]       state, nstate;
    logic [IPW-1:0]   ip, nip, ip1;
    instr_t           ins;
    logic             ip_ok, a_ok, b_ok, c_ok, limit_hit, launch;
    logic [WIDTH-1:0] la, lb, lc;
    logic             retire, pop, emit, drop, end_ok, end_err;
    logic             lm_we;
    logic [WIDTH-1:0] lm_wd;
    logic             fifo_full;
    logic [WIDTH-1:0] fifo_dout;
    logic [CW-1:0]    fifo_count;

    zero_stream_fifo #(.WIDTH(WIDTH), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clock (clock),
        .reset (reset),
        .push  (in_valid),
        .din   (in_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign in_ready = !fifo_full;
    assign running  = (state == S_EXEC) || (state == S_WAIT_IN) || (state == S_WAIT_OUT);
    assign launch   = start && ((state == S_IDLE) || (state == S_DONE));

`ifdef ZERO_STEP_LIMIT_EN
    assign limit_hit = (step_count >= 32'(MAX_STEPS));
`else
    logic [31:0] unused_max_steps;
    assign unused_max_steps = 32'(MAX_STEPS);
    assign limit_hit        = 1'b0;
`endif

    // Operands are range-checked before any local-memory access is allowed to take effect.
    assign ip_ok = (ip < IPW'(NPROG));
    assign ins   = prog[ip[PW-1:0]];
    assign ip1   = ip + IPW'(1);
    assign a_ok  = ({1'b0, ins.a} < IPW'(NLOCAL));
    assign b_ok  = ({1'b0, ins.b} < IPW'(NLOCAL));
    assign c_ok  = ({1'b0, ins.c} < IPW'(NLOCAL));
    assign la    = lmem[ins.a[LW-1:0]];
    assign lb    = lmem[ins.b[LW-1:0]];
    assign lc    = lmem[ins.c[LW-1:0]];

    always_comb begin
        nstate  = state;
        nip     = ip;
        retire  = 1'b0;
        pop     = 1'b0;
        emit    = 1'b0;
        drop    = 1'b0;
        end_ok  = 1'b0;
        end_err = 1'b0;
        lm_we   = 1'b0;
        lm_wd   = '0;
        case (state)
            S_EXEC: begin
                if (limit_hit) begin
                    end_err = 1'b1;
                end else if (!ip_ok) begin
                    end_ok = 1'b1;
                end else begin
                    case (ins.op)
                        OP_LABEL: begin
                            nip = ip1; retire = 1'b1;
                        end
                        OP_INSIZE: begin
                            if (!a_ok) end_err = 1'b1;
                            else begin
                                lm_we = 1'b1; lm_wd = WIDTH'(fifo_count);
                                nip = ip1; retire = 1'b1;
                            end
                        end
                        OP_IN: begin
                            if (!a_ok) end_err = 1'b1;
                            else if (fifo_count != '0) begin
                                pop = 1'b1; lm_we = 1'b1; lm_wd = fifo_dout;
                                nip = ip1; retire = 1'b1;
                            end else nstate = S_WAIT_IN;
                        end
                        OP_OUT: begin
                            if (!a_ok) end_err = 1'b1;
                            else begin
                                emit = 1'b1; nstate = S_WAIT_OUT;
                            end
                        end
                        OP_JMP: begin
                            nip = {1'b0, ins.a}; retire = 1'b1;
                        end
                        OP_JFALSE, OP_JTRUE: begin
                            if (!a_ok) end_err = 1'b1;
                            else begin
                                retire = 1'b1;
                                nip = ((la == '0) == (ins.op == OP_JFALSE)) ? {1'b0, ins.b} : ip1;
                            end
                        end
                        OP_MOV: begin
                            if (!a_ok) end_err = 1'b1;
                            else begin
                                lm_we = 1'b1; lm_wd = WIDTH'(ins.b);
                                nip = ip1; retire = 1'b1;
                            end
                        end
                        OP_ADD, OP_SUB: begin
                            if (!(a_ok && b_ok && c_ok)) end_err = 1'b1;
                            else begin
                                lm_we = 1'b1;
                                lm_wd = (ins.op == OP_ADD) ? lb + lc : lb - lc;
                                nip = ip1; retire = 1'b1;
                            end
                        end
                        OP_HALT: begin
                            end_ok = 1'b1; retire = 1'b1;
                        end
                        default: end_err = 1'b1;
                    endcase
                end
                if (end_ok || end_err) nstate = S_DONE;
            end
            S_WAIT_IN: begin
                if (fifo_count != '0) begin
                    pop = 1'b1; lm_we = 1'b1; lm_wd = fifo_dout;
                    nip = ip1; retire = 1'b1; nstate = S_EXEC;
                end
            end
            S_WAIT_OUT: begin
                if (out_ready) begin
                    drop = 1'b1; nip = ip1; retire = 1'b1; nstate = S_EXEC;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (prog_we && !running && ({1'b0, prog_addr} < IPW'(NPROG)))
            prog[prog_addr[PW-1:0]] <= instr_t'(prog_data);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            ip         <= '0;
            step_count <= '0;
            finished   <= 1'b0;
            success    <= 1'b0;
            error      <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            for (int i = 0; i < NLOCAL; i++) lmem[i] <= '0;
        end else if (launch) begin
            state      <= S_EXEC;
            ip         <= '0;
            step_count <= '0;
            finished   <= 1'b0;
            success    <= 1'b0;
            error      <= 1'b0;
            for (int i = 0; i < NLOCAL; i++) lmem[i] <= '0;
        end else begin
            state <= nstate;
            ip    <= nip;
            if (retire && (step_count != '1)) step_count <= step_count + 32'd1;
            if (lm_we) lmem[ins.a[LW-1:0]] <= lm_wd;
            if (emit) begin
                out_valid <= 1'b1;
                out_data  <= la;
            end else if (drop) begin
                out_valid <= 1'b0;
            end
            if (end_ok || end_err) begin
                finished <= 1'b1;
                success  <= end_ok;
                error    <= end_err;
            end
        end
    end

endmodule

// File: tb/tb_zero_stream_machine.sv
// Directed bench for zero_stream_machine: stream programs, stalls, wrap arithmetic, reset and step limit.
module tb_zero_stream_machine;
    logic        clock = 0;
    logic        reset, start, prog_we, in_valid, out_ready;
    logic [7:0]  prog_addr;
    logic [27:0] prog_data;
    logic [11:0] in_data, out_data;
    logic        in_ready, out_valid, running, finished, success, error;
    logic [31:0] step_count;

    logic        w4_start, w4_prog_we, w4_in_valid, w4_out_ready;
    logic [3:0]  w4_in_data, w4_out_data;
    logic        w4_in_ready, w4_out_valid, w4_running, w4_finished, w4_success, w4_error;
    logic [31:0] w4_step_count;

    int ncmp = 0, nfail = 0;
    int q[$], q4[$];
    logic        stall_prev = 0;
    logic [11:0] held = 0;
    int exp_ref[6] = '{3, 33, 2, 22, 1, 11};

    always #5 clock = ~clock;

    zero_stream_machine u_dut (
        .clock(clock), .reset(reset), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .running(running),
        .finished(finished), .success(success), .error(error), .step_count(step_count)
    );

    zero_stream_machine #(.WIDTH(4)) u_w4 (
        .clock(clock), .reset(reset), .start(w4_start), .prog_we(w4_prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .in_valid(w4_in_valid), .in_ready(w4_in_ready), .in_data(w4_in_data),
        .out_valid(w4_out_valid), .out_ready(w4_out_ready), .out_data(w4_out_data), .running(w4_running),
        .finished(w4_finished), .success(w4_success), .error(w4_error), .step_count(w4_step_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [27:0] mk(input int op, input int a, input int b, input int c);
        return {4'(op), 8'(a), 8'(b), 8'(c)};
    endfunction

    task automatic load(input bit to_w4, input int addr, input logic [27:0] d);
        prog_addr = 8'(addr);
        prog_data = d;
        if (to_w4) w4_prog_we = 1; else prog_we = 1;
        tick;
        prog_we = 0;
        w4_prog_we = 0;
    endtask

    task automatic load_ref;
        load(0, 0, mk(1, 0, 0, 0));   // inSize L0
        load(0, 1, mk(5, 0, 6, 0));   // jFalse L0 -> 6
        load(0, 2, mk(2, 1, 0, 0));   // in L1
        load(0, 3, mk(3, 0, 0, 0));   // out L0
        load(0, 4, mk(3, 1, 0, 0));   // out L1
        load(0, 5, mk(4, 0, 0, 0));   // jmp 0
        load(0, 6, mk(15, 0, 0, 0));  // halt
    endtask

    task automatic push3;
        in_valid = 1;
        in_data = 33; tick;
        in_data = 22; tick;
        in_data = 11; tick;
        in_valid = 0;
    endtask

    task automatic go;
        start = 1; tick; start = 0;
    endtask

    task automatic wait_fin(input int maxc, input bit toggle, input string tag);
        int n = 0;
        while (!finished && n < maxc) begin
            if (toggle) out_ready = (n % 3 == 0);
            tick;
            n++;
        end
        out_ready = 1;
        chk(tag, finished, 1);
    endtask

    task automatic chk_ref(input string tag);
        chk({tag, "_len"}, q.size(), 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("%s_out%0d", tag, i), (i < q.size()) ? q[i] : 32'hdead, exp_ref[i]);
    endtask

    // Output capture plus the hold rule for a stalled output word.
    always @(negedge clock) begin
        if (reset) stall_prev = 0;
        else begin
            if (stall_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, held);
            end
            if (out_valid && out_ready) q.push_back(out_data);
            stall_prev = out_valid && !out_ready;
            held = out_data;
        end
        if (w4_out_valid && w4_out_ready) q4.push_back(w4_out_data);
    end

    initial begin
        int n;
        reset = 1; start = 0; prog_we = 0; prog_addr = 0; prog_data = 0;
        in_valid = 0; in_data = 0; out_ready = 1;
        w4_start = 0; w4_prog_we = 0; w4_in_valid = 0; w4_in_data = 0; w4_out_ready = 1;
        tick; tick;
        reset = 0;

        chk("rst_running", running, 0);
        chk("rst_finished", finished, 0);
        chk("rst_success", success, 0);
        chk("rst_error", error, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_step_count", step_count, 0);
        chk("rst_in_ready", in_ready, 1);

        // Reference loop, sink always ready
        load_ref;
        push3;
        go;
        wait_fin(300, 0, "ref_finished");
        chk("ref_success", success, 1);
        chk("ref_error", error, 0);
        chk("ref_running", running, 0);
        chk_ref("ref");

        // Same program restarted from DONE, sink ready one cycle in three
        q.delete();
        push3;
        go;
        wait_fin(600, 1, "bp_finished");
        chk("bp_success", success, 1);
        chk_ref("bp");

        // in with empty FIFO stalls; stall cycles do not count as steps
        load(0, 0, mk(2, 2, 0, 0));
        load(0, 1, mk(3, 2, 0, 0));
        load(0, 2, mk(15, 0, 0, 0));
        q.delete();
        go;
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("stall_running", running, 1);
            chk("stall_steps", step_count, 0);
            chk("stall_out_valid", out_valid, 0);
        end
        in_valid = 1; in_data = 7; tick; in_valid = 0;
        n = 0;
        while (!out_valid && n < 20) begin tick; n++; end
        chk("win_out_valid", out_valid, 1);
        chk("win_out_data", out_data, 7);
        chk("win_steps", step_count, 1);
        wait_fin(50, 0, "win_finished");
        chk("win_success", success, 1);

        // 4-bit instance: wraparound add/sub, then illegal opcode
        load(1, 0, mk(7, 0, 15, 0));
        load(1, 1, mk(7, 1, 1, 0));
        load(1, 2, mk(8, 2, 0, 1));
        load(1, 3, mk(3, 2, 0, 0));
        load(1, 4, mk(7, 3, 0, 0));
        load(1, 5, mk(9, 4, 3, 1));
        load(1, 6, mk(3, 4, 0, 0));
        load(1, 7, mk(12, 0, 0, 0));
        w4_start = 1; tick; w4_start = 0;
        n = 0;
        while (!w4_finished && n < 100) begin tick; n++; end
        chk("w4_finished", w4_finished, 1);
        chk("w4_error", w4_error, 1);
        chk("w4_success", w4_success, 0);
        chk("w4_len", q4.size(), 2);
        chk("w4_add_wrap", (q4.size() > 0) ? q4[0] : 32'hdead, 0);
        chk("w4_sub_wrap", (q4.size() > 1) ? q4[1] : 32'hdead, 15);

        // Reset while an output word is pending
        load_ref;
        push3;
        out_ready = 0;
        go;
        n = 0;
        while (!out_valid && n < 20) begin tick; n++; end
        chk("wo_out_valid", out_valid, 1);
        chk("wo_out_data", out_data, 3);
        tick; tick;
        reset = 1; tick;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_running", running, 0);
        chk("mid_rst_finished", finished, 0);
        reset = 0;
        out_ready = 1;
        q.delete();
        go;
        wait_fin(50, 0, "empty_finished");
        chk("empty_success", success, 1);
        chk("empty_no_output", q.size(), 0);
        push3;
        go;
        wait_fin(300, 0, "rerun_finished");
        chk("rerun_success", success, 1);
        chk_ref("rerun");

        // Jump past the end of program memory ends successfully without retiring
        load(0, 0, mk(4, 64, 0, 0));
        go;
        wait_fin(20, 0, "ipend_finished");
        chk("ipend_success", success, 1);
        chk("ipend_error", error, 0);
        chk("ipend_steps", step_count, 1);

        // Out-of-range local operand
        load(0, 0, mk(7, 16, 5, 0));
        go;
        wait_fin(20, 0, "badloc_finished");
        chk("badloc_error", error, 1);
        chk("badloc_success", success, 0);
        chk("badloc_steps", step_count, 0);

        // FIFO fills to IN_DEPTH then backpressures; extra push ignored
        in_valid = 1; in_data = 1;
        repeat (8) tick;
        chk("fifo_full_ready", in_ready, 0);
        tick;
        chk("fifo_still_full", in_ready, 0);
        in_valid = 0;
        reset = 1; tick; reset = 0;
        chk("fifo_rst_ready", in_ready, 1);

        // Endless jmp 0; a program write while running must not land
        load(0, 0, mk(4, 0, 0, 0));
        go;
        repeat (500) tick;
        load(0, 0, mk(15, 0, 0, 0));
        repeat (599) tick;
`ifdef ZERO_STEP_LIMIT_EN
        chk("lim_finished", finished, 1);
        chk("lim_error", error, 1);
        chk("lim_success", success, 0);
        chk("lim_steps", step_count, 1024);
`else
        chk("nolim_running", running, 1);
        chk("nolim_error", error, 0);
        chk("nolim_finished", finished, 0);
        chk("nolim_steps", step_count, 1100);
`endif
        reset = 1; tick; reset = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
